// File: rtl/lcd_char_writer.sv
// HD44780-style character writer: power-up init, then host characters onto the LCD bus
// with cursor tracking. Optional macro LCD_NEWLINE_EN turns 0x0A into a line change.
module lcd_char_writer #(
  parameter int unsigned COLS           = 16,
  parameter int unsigned SETUP_CYC      = 4,
  parameter int unsigned EN_PULSE_CYC   = 12,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 80000,
  parameter int unsigned PWRUP_CYC      = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       init_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_ON
);

  localparam int unsigned MAX_A    = (PWRUP_CYC > CLEAR_WAIT_CYC) ? PWRUP_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned MAX_B    = (CMD_WAIT_CYC > EN_PULSE_CYC) ? CMD_WAIT_CYC : EN_PULSE_CYC;
  localparam int unsigned MAX_C    = (SETUP_CYC > MAX_B) ? SETUP_CYC : MAX_B;
  localparam int unsigned MAX_WAIT = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int unsigned COL_W    = $clog2(COLS);
  localparam int unsigned INIT_LEN = 4;

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_IDLE  = 3'd4;

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [COL_W-1:0] col, col_n;
  logic             line, line_n;
  logic [2:0]       init_idx, init_idx_n;
  logic             pend, pend_n;
  logic [7:0]       pend_cmd, pend_cmd_n;
  logic             rs_n;
  logic [7:0]       data_n;
  logic             init_done_n;
  logic [CNT_W-1:0] wait_last_c;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      3'd3:    return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

  // Clear needs the long settle; the byte on the bus is still the one just strobed.
  assign wait_last_c = (!LCD_RS && LCD_DATA == 8'h01) ? CNT_W'(CLEAR_WAIT_CYC - 1)
                                                      : CNT_W'(CMD_WAIT_CYC - 1);
  assign LCD_RW = 1'b0;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    col_n       = col;
    line_n      = line;
    init_idx_n  = init_idx;
    pend_n      = pend;
    pend_cmd_n  = pend_cmd;
    rs_n        = LCD_RS;
    data_n      = LCD_DATA;
    init_done_n = init_done;
    case (state)
      S_PWRUP: begin
        if (cnt == CNT_W'(PWRUP_CYC - 1)) begin
          cnt_n      = '0;
          state_n    = S_SETUP;
          rs_n       = 1'b0;
          data_n     = init_cmd(3'd0);
          init_idx_n = 3'd1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          cnt_n   = '0;
          state_n = S_PULSE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt == CNT_W'(EN_PULSE_CYC - 1)) begin
          cnt_n   = '0;
          state_n = S_WAIT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt == wait_last_c) begin
          cnt_n = '0;
          if (init_idx < 3'(INIT_LEN)) begin
            state_n    = S_SETUP;
            rs_n       = 1'b0;
            data_n     = init_cmd(init_idx);
            init_idx_n = init_idx + 3'd1;
          end else if (pend) begin
            state_n = S_SETUP;
            rs_n    = 1'b0;
            data_n  = pend_cmd;
            pend_n  = 1'b0;
          end else begin
            state_n     = S_IDLE;
            init_done_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (char_valid) begin
          state_n = S_SETUP;
`ifdef LCD_NEWLINE_EN
          if (char_data == 8'h0A) begin
            rs_n   = 1'b0;
            data_n = line ? 8'h80 : 8'hC0;
            col_n  = '0;
            line_n = ~line;
          end else
`endif
          begin
            rs_n   = 1'b1;
            data_n = char_data;
            // Last column: wrap cursor and queue the DDRAM address of the other line.
            if (col == COL_W'(COLS - 1)) begin
              col_n      = '0;
              line_n     = ~line;
              pend_n     = 1'b1;
              pend_cmd_n = line ? 8'h80 : 8'hC0;
            end else begin
              col_n = col + COL_W'(1);
            end
          end
        end
      end
      default: state_n = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_PWRUP;
      cnt        <= '0;
      col        <= '0;
      line       <= 1'b0;
      init_idx   <= '0;
      pend       <= 1'b0;
      pend_cmd   <= '0;
      LCD_RS     <= 1'b0;
      LCD_DATA   <= '0;
      LCD_EN     <= 1'b0;
      LCD_ON     <= 1'b0;
      char_ready <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      col        <= col_n;
      line       <= line_n;
      init_idx   <= init_idx_n;
      pend       <= pend_n;
      pend_cmd   <= pend_cmd_n;
      LCD_RS     <= rs_n;
      LCD_DATA   <= data_n;
      LCD_EN     <= (state_n == S_PULSE);
      LCD_ON     <= 1'b1;
      char_ready <= (state_n == S_IDLE);
      init_done  <= init_done_n;
    end
  end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer: random host characters against a queue model of the
// expected LCD bus cycles, with timing of every EN pulse monitored.
module tb_lcd_char_writer;

  localparam int unsigned COLS           = 4;
  localparam int unsigned SETUP_CYC      = 2;
  localparam int unsigned EN_PULSE_CYC   = 3;
  localparam int unsigned CMD_WAIT_CYC   = 5;
  localparam int unsigned CLEAR_WAIT_CYC = 20;
  localparam int unsigned PWRUP_CYC      = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready, init_done, LCD_EN, LCD_RS, LCD_RW, LCD_ON;
  logic [7:0] LCD_DATA;

  lcd_char_writer #(
    .COLS(COLS), .SETUP_CYC(SETUP_CYC), .EN_PULSE_CYC(EN_PULSE_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC), .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC), .PWRUP_CYC(PWRUP_CYC)
  ) dut (
    .clk(clk), .reset(reset), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .init_done(init_done), .LCD_DATA(LCD_DATA),
    .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_ON(LCD_ON)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected {rs,data} words in bus order, plus cursor.
  logic [8:0] exp_q[$];
  int m_col = 0;
  int m_line = 0;

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    m_col  = 0;
    m_line = 0;
  endtask

  task automatic model_char(input logic [7:0] c, output logic [8:0] first);
`ifdef LCD_NEWLINE_EN
    if (c == 8'h0A) begin
      first  = {1'b0, (m_line == 0) ? 8'hC0 : 8'h80};
      exp_q.push_back(first);
      m_col  = 0;
      m_line = 1 - m_line;
      return;
    end
`endif
    first = {1'b1, c};
    exp_q.push_back(first);
    m_col++;
    if (m_col == COLS) begin
      m_col  = 0;
      m_line = 1 - m_line;
      exp_q.push_back({1'b0, (m_line == 1) ? 8'hC0 : 8'h80});
    end
  endtask

  // Bus monitor: pulse content, EN width, and the idle gaps around each pulse.
  logic [8:0] cur_word = 9'h000;
  logic prev_en = 1'b0;
  logic prev_rdy = 1'b0;
  int busy_cnt = 0;
  int en_w = 0;
  int gap_w = PWRUP_CYC;
  int init_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_en = 1'b0; prev_rdy = 1'b0; busy_cnt = 0; en_w = 0;
        gap_w = PWRUP_CYC; init_seen = 0;
      end else begin
        if (LCD_EN && !prev_en) begin
          check("en_rise_delay", 32'(busy_cnt), 32'(gap_w + SETUP_CYC));
          check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) cur_word = exp_q.pop_front();
          check("bus_word", 32'({LCD_RS, LCD_DATA}), 32'(cur_word));
          check("init_done_early", 32'(init_done), 32'(init_seen >= 4));
          init_seen++;
          en_w = 0;
          busy_cnt = 0;
        end
        if (LCD_EN) begin
          en_w++;
          check("bus_hold_pulse", 32'({LCD_RS, LCD_DATA}), 32'(cur_word));
        end else if (prev_en) begin
          check("en_width", 32'(en_w), 32'(EN_PULSE_CYC));
          check("bus_hold_wait", 32'({LCD_RS, LCD_DATA}), 32'(cur_word));
          gap_w = (cur_word == 9'h001) ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;
        end
        if (char_ready && !prev_rdy) begin
          check("ready_delay", 32'(busy_cnt), 32'(gap_w));
          check("init_done", 32'(init_done), 32'd1);
          gap_w = 0;
          busy_cnt = 0;
        end
        if (!LCD_EN && !char_ready) busy_cnt++;
        prev_en  = LCD_EN;
        prev_rdy = char_ready;
      end
    end
  end

  task automatic wait_ready(input int limit);
    int g = 0;
    while (char_ready !== 1'b1 && g < limit) begin
      @(negedge clk);
      g++;
    end
    check("wait_ready_timeout", 32'(g < limit), 32'd1);
  endtask

  // Host: noise on char_data while busy; the intended byte is presented in the ready cycle.
  task automatic send_char(input logic [7:0] c, input bit keep);
    int g = 0;
    logic [8:0] first;
    char_valid = 1'b1;
    while (char_ready !== 1'b1 && g < 2000) begin
      char_data = 8'($urandom);
      @(negedge clk);
      g++;
    end
    check("send_timeout", 32'(g < 2000), 32'd1);
    char_data = c;
    model_char(c, first);
    @(negedge clk);
    check("ready_drop", 32'(char_ready), 32'd0);
    check("capture_bus", 32'({LCD_RS, LCD_DATA}), 32'(first));
    if (!keep) char_valid = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("lcd_on_before_edge", 32'(LCD_ON), 32'd0);
    @(negedge clk);
    check("lcd_on", 32'(LCD_ON), 32'd1);
    wait_ready(500);
    check("init_drained", 32'(exp_q.size()), 32'd0);
    check("init_done_idle", 32'(init_done), 32'd1);
  endtask

  initial begin
    logic [7:0] c;
    int g;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_data", 32'(LCD_DATA), 32'd0);
    check("rst_en", 32'(LCD_EN), 32'd0);
    check("rst_rs", 32'(LCD_RS), 32'd0);
    check("rst_rw", 32'(LCD_RW), 32'd0);
    check("rst_on", 32'(LCD_ON), 32'd0);
    check("rst_ready", 32'(char_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    release_reset();

    // Two full lines streamed back to back: 0xC0 then 0x80 line commands.
    for (int i = 0; i < 8; i++) send_char(8'h41 + 8'(i), 1'b1);
    char_valid = 1'b0;
    wait_ready(500);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 9) == 0) ? 8'h0A : 8'($urandom_range(32, 126));
      send_char(c, 1'($urandom_range(0, 1)));
      if (!char_valid) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    char_valid = 1'b0;
    wait_ready(500);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of an EN pulse.
    send_char(8'h5A, 1'b0);
    g = 0;
    while (LCD_EN !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("pulse_seen", 32'(g < 100), 32'd1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("abort_en", 32'(LCD_EN), 32'd0);
    check("abort_on", 32'(LCD_ON), 32'd0);
    check("abort_data", 32'(LCD_DATA), 32'd0);
    check("abort_ready", 32'(char_ready), 32'd0);
    repeat (2) @(negedge clk);
    release_reset();

    // Cursor restarted at col 0: line command after exactly COLS characters.
    for (int i = 0; i < COLS + 1; i++) send_char(8'($urandom_range(32, 126)), 1'b0);
    wait_ready(500);
    check("post_reset_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
